uart_tx_serializer: RTL and testbench
=====================================

// Module: uart_tx_serializer
// PURPOSE
//  Byte-wide UART transmitter. Sits directly downstream of the send sequencer that pulses tx_send and muxes the sum bytes.
//  Latches one byte per start pulse and serializes it on tx_line as start + 8 data (LSB first) + optional parity + stop.
//  Reports frame progress via tx_busy/tx_done. Upstream must gate on these, not on fixed delays
//  (one 8N1 frame at 868 clk/bit = 8680 cycles).
// PARAMETERS
//  CLKS_PER_BIT  868  clk cycles per UART bit (100 MHz / 115200); legal range 2..65535
//  PARITY_EN     0    1 = insert parity bit after data bits
//  PARITY_ODD    0    0 = even parity, 1 = odd parity (ignored when PARITY_EN=0)
//  STOP_BITS     1    number of stop bits, 1 or 2
// PORTS
//  clk       in   1  system clock
//  reset     in   1  synchronous, active-high reset
//  tx_start  in   1  request to send tx_data; sampled only in IDLE
//  tx_data   in   8  byte to send; captured on the accepting edge
//  tx_line   out  1  serial output, idle high
//  tx_busy   out  1  high from the cycle after acceptance through the last stop-bit cycle
//  tx_done   out  1  one-cycle pulse on the last cycle of the final stop bit
// BEHAVIOUR
//  - Reset: tx_line=1, tx_busy=0, tx_done=0, state=IDLE, bit counter=0, shift reg=0.
//    Takes effect on the next edge, including mid-frame. The frame is aborted and no tx_done is issued.
//  - States: IDLE -> START -> DATA -> [PARITY if PARITY_EN] -> STOP -> IDLE.
//  - IDLE:
//    - On tx_start=1, latch tx_data into the shift register and compute parity (^data, inverted if PARITY_ODD).
//    - Enter START. tx_line goes low on the next cycle (latency 1).
//  - Each bit holds tx_line stable for exactly CLKS_PER_BIT cycles. The bit-period counter resets on every state change.
//  - DATA: shift right once per bit period; 8 bit periods, index 0..7; then PARITY or STOP.
//  - STOP: tx_line=1 for STOP_BITS*CLKS_PER_BIT cycles.
//    - tx_done=1 on the final cycle; tx_busy is still 1 in that cycle.
//    - The state returns to IDLE at the following edge.
//  - tx_busy = (state != IDLE), registered. tx_line is registered, so there are no glitches.
//  - Frame length = (1+8+PARITY_EN+STOP_BITS)*CLKS_PER_BIT cycles. Minimum start-to-start spacing is frame length + 1
//    (one IDLE cycle, line high).
//  - tx_start while busy: ignored, no queueing, tx_data not sampled. tx_data changes mid-frame: no effect.
//  - tx_start held high continuously: a new frame is accepted in every IDLE cycle, giving back-to-back frames
//    with one idle-high cycle between them.
//  - The bit-period counter width is $clog2(CLKS_PER_BIT). The bit index counter is 3 bits, with no wrap beyond 7.
// STRUCTURE
//  - Shared package uart_pkg: state encoding localparams (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4),
//    UART_DATA_BITS=8, default CLKS_PER_BIT.
//  - Sub-module uart_bit_timer: counter with clear input.
//    - Emits bit_end when count == CLKS_PER_BIT-1; shared with a future uart_rx.
//  - The top contains the FSM, shift register, parity register, stop-bit counter and output registers.
// TESTING (CLKS_PER_BIT=4 unless noted; cycle 0 = accepting edge)
//  1. Reset for 3 cycles, idle, no tx_start
//     -> tx_line=1, tx_busy=0, tx_done=0 throughout.
//  2. tx_start pulse with tx_data=8'hA5, 8N1
//     -> tx_line low cycles 1-4; data 1,0,1,0,0,1,0,1 in 4-cycle slots (cycles 5-36); high cycles 37-40.
//     -> tx_done=1 only at cycle 40; tx_busy=1 cycles 1-40.
//  3. Case 2 plus tx_start with tx_data=8'hFF at cycle 12
//     -> waveform identical to 8'hA5, no second frame, single tx_done.
//  4. PARITY_EN=1, tx_data=8'h03: PARITY_ODD=0 -> parity slot (cycles 37-40) low; PARITY_ODD=1 -> high.
//     -> tx_done at cycle 44 in both cases.
//  5. Reset asserted at cycle 18 (data bit 3)
//     -> tx_line=1 and tx_busy=0 from cycle 19, no tx_done.
//     -> a subsequent tx_start with 8'h00 gives a clean 40-cycle frame.
//  6. tx_start held high, tx_data=8'h55 then 8'h0F after the first acceptance
//     -> second frame's start bit begins at cycle 42 (one idle-high cycle at 41).
//     -> two tx_done pulses, 41 cycles apart.
//  Checker: a scoreboard UART-RX model samples mid-bit and compares against the accepted bytes.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: state encoding and shared constants for the UART blocks.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

    localparam int UART_DATA_BITS   = 8;
    localparam int DEF_CLKS_PER_BIT = 868;

endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: bit-period counter with clear; bit_end marks the last cycle of a bit.
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic bit_end
);

    localparam int CW = $clog2(CLKS_PER_BIT);

    logic [CW-1:0] count;

    assign bit_end = count == CW'(CLKS_PER_BIT - 1);

    always_ff @(posedge clk)
        count <= (reset || clear || bit_end) ? '0 : count + CW'(1);

endmodule

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: byte-wide UART transmitter, start + 8 data LSB first + optional parity + stop.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx_line,
    output logic       tx_busy,
    output logic       tx_done
);

    uart_state_t state, state_n;
    logic [7:0]  shift, shift_n;
    logic [2:0]  idx, idx_n;
    logic        par, par_n, stop_cnt, stop_n, line_n, bit_end, last_stop;

    // The timer restarts on every state change so each bit gets a full period.
    uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (state_n != state),
        .bit_end(bit_end)
    );

    assign last_stop = stop_cnt == 1'(STOP_BITS - 1);
    assign tx_done   = state == STOP && bit_end && last_stop;

    always_comb begin
        state_n = state;
        shift_n = shift;
        par_n   = par;
        idx_n   = idx;
        stop_n  = stop_cnt;
        case (state)
            IDLE: if (tx_start) begin
                state_n = START;
                shift_n = tx_data;
                par_n   = (^tx_data) ^ (PARITY_ODD != 0);
                idx_n   = '0;
                stop_n  = 1'b0;
            end
            START: if (bit_end) state_n = DATA;
            DATA: if (bit_end) begin
                shift_n = shift >> 1;
                idx_n   = idx + 3'd1;
                if (idx == 3'(UART_DATA_BITS - 1)) state_n = PARITY_EN != 0 ? PARITY : STOP;
            end
            PARITY: if (bit_end) state_n = STOP;
            STOP: if (bit_end) begin
                state_n = last_stop ? IDLE : STOP;
                stop_n  = 1'b1;
            end
            default: state_n = IDLE;
        endcase
        // Line value is taken from next-state values so tx_line can be a plain register.
        line_n = state_n == START  ? 1'b0 :
                 state_n == DATA   ? shift_n[0] :
                 state_n == PARITY ? par_n : 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            shift    <= '0;
            par      <= 1'b0;
            idx      <= '0;
            stop_cnt <= 1'b0;
            tx_line  <= 1'b1;
            tx_busy  <= 1'b0;
        end else begin
            state    <= state_n;
            shift    <= shift_n;
            par      <= par_n;
            idx      <= idx_n;
            stop_cnt <= stop_n;
            tx_line  <= line_n;
            tx_busy  <= state_n != IDLE;
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb_uart_tx_serializer: directed checks of the UART transmitter at 4 clk/bit, 8N1 and 8E1/8O1.
module tb_uart_tx_serializer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start [3];
    logic [7:0] data  [3];
    logic       line  [3];
    logic       busy  [3];
    logic       done  [3];
    int         checks = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    uart_tx_serializer #(.CLKS_PER_BIT(4)) dut0 (
        .clk(clk), .reset(reset), .tx_start(start[0]), .tx_data(data[0]),
        .tx_line(line[0]), .tx_busy(busy[0]), .tx_done(done[0])
    );
    uart_tx_serializer #(.CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0)) dut1 (
        .clk(clk), .reset(reset), .tx_start(start[1]), .tx_data(data[1]),
        .tx_line(line[1]), .tx_busy(busy[1]), .tx_done(done[1])
    );
    uart_tx_serializer #(.CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1)) dut2 (
        .clk(clk), .reset(reset), .tx_start(start[2]), .tx_data(data[2]),
        .tx_line(line[2]), .tx_busy(busy[2]), .tx_done(done[2])
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_idle(input int u, input string tag);
        check({tag, " line"}, 8'(line[u]), 8'd1);
        check({tag, " busy"}, 8'(busy[u]), 8'd0);
        check({tag, " done"}, 8'(done[u]), 8'd0);
    endtask

    // Hand-derived waveform, cycle k counted from the accepting edge (k=0).
    function automatic logic exp_line(input logic [7:0] d, input int pen, input int podd, input int k);
        if (k >= 1 && k <= 4) return 1'b0;
        if (k >= 5 && k <= 36) return d[(k - 5) / 4];
        if (pen != 0 && k >= 37 && k <= 40) return (^d) ^ (podd != 0);
        return 1'b1;
    endfunction

    // Checks cycles 1..last of a frame already accepted; also decodes it mid-bit like a receiver.
    task automatic frame(input int u, input logic [7:0] d, input int pen, input int podd, input int poke);
        int last;
        logic [7:0] rx;
        last = 40 + 4 * pen;
        rx = 8'h00;
        for (int k = 1; k <= last; k++) begin
            check($sformatf("line u%0d k%0d", u, k), 8'(line[u]), 8'(exp_line(d, pen, podd, k)));
            check($sformatf("busy u%0d k%0d", u, k), 8'(busy[u]), 8'd1);
            check($sformatf("done u%0d k%0d", u, k), 8'(done[u]), 8'(k == last));
            if (k >= 5 && k <= 36 && (k - 5) % 4 == 2) rx[(k - 5) / 4] = line[u];
            if (k == poke) begin
                start[u] = 1'b1;
                data[u]  = 8'hFF;
            end
            step();
            if (k == poke) start[u] = 1'b0;
        end
        check($sformatf("rx byte u%0d", u), rx, d);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            start[i] = 1'b0;
            data[i]  = 8'h00;
        end
        // 1: reset, idle
        for (int i = 0; i < 3; i++) begin
            step();
            check_idle(0, $sformatf("reset c%0d", i));
        end
        reset = 1'b0;
        step();
        check_idle(0, "post reset");
        // 2: plain 8N1 frame
        start[0] = 1'b1; data[0] = 8'hA5;
        step();
        start[0] = 1'b0;
        frame(0, 8'hA5, 0, 0, -1);
        check_idle(0, "after A5");
        // 3: tx_start with new data mid-frame is ignored
        start[0] = 1'b1; data[0] = 8'hA5;
        step();
        start[0] = 1'b0;
        frame(0, 8'hA5, 0, 0, 12);
        for (int i = 0; i < 8; i++) begin
            check_idle(0, $sformatf("no second frame c%0d", i));
            step();
        end
        // 4: even and odd parity on 8'h03
        start[1] = 1'b1; data[1] = 8'h03;
        step();
        start[1] = 1'b0;
        frame(1, 8'h03, 1, 0, -1);
        check_idle(1, "after even");
        start[2] = 1'b1; data[2] = 8'h03;
        step();
        start[2] = 1'b0;
        frame(2, 8'h03, 1, 1, -1);
        check_idle(2, "after odd");
        // 5: reset during data bit 3 aborts the frame
        start[0] = 1'b1; data[0] = 8'hA5;
        step();
        start[0] = 1'b0;
        for (int k = 1; k <= 18; k++) begin
            check($sformatf("abort line k%0d", k), 8'(line[0]), 8'(exp_line(8'hA5, 0, 0, k)));
            if (k == 18) reset = 1'b1;
            step();
        end
        check_idle(0, "abort k19");
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            check_idle(0, $sformatf("abort idle c%0d", i));
        end
        start[0] = 1'b1; data[0] = 8'h00;
        step();
        start[0] = 1'b0;
        frame(0, 8'h00, 0, 0, -1);
        check_idle(0, "after 00");
        // 6: tx_start held high gives back-to-back frames with one idle cycle
        start[0] = 1'b1; data[0] = 8'h55;
        step();
        data[0] = 8'h0F;
        frame(0, 8'h55, 0, 0, -1);
        check_idle(0, "gap k41");
        step();
        start[0] = 1'b0;
        frame(0, 8'h0F, 0, 0, -1);
        check_idle(0, "after 0F");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
